sobel_frame_ctrl: RTL



---
 rtl/sobel_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame-synchronous configuration and statistics controller for the Sobel
// edge detector. Host writes a shadow threshold and control bits that are
// committed to the detector only at vertical-blanking start; edge pixels are
// counted per frame and a frame counter / frame-done pulse are maintained.
// Optional feature macro: SOBEL_AUTO_THRESH_EN (auto threshold adjust, ctrl bit2).
module sobel_frame_ctrl #(
  parameter logic [10:0]      THR_DEFAULT  = 11'd100,
  parameter logic [10:0]      THR_MAX      = 11'd2040,
  parameter logic [10:0]      THR_MIN      = 11'd8,
  parameter int               CNT_W        = 21,
  parameter logic [CNT_W-1:0] TARGET_EDGES = 21'd20000,
  parameter logic [CNT_W-1:0] HYST         = 21'd2000,
  parameter logic [10:0]      STEP         = 11'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr_en,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  input  logic             cfg_rd_en,
  output logic [15:0]      cfg_rdata,
  output logic             cfg_rvalid,
  input  logic             vsync,
  input  logic             href,
  input  logic             clken,
  input  logic             edge_bit,
  output logic [10:0]      sobel_threshold,
  output logic             cfg_pending,
  output logic             frame_done,
  output logic [CNT_W-1:0] edge_count,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {
    S_WAIT_BLANK = 2'd0,
    S_ACTIVE     = 2'd1,
    S_COMMIT     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [10:0]      THR_OFF = 11'h7FF;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_vsync_q;
  logic [10:0]        r_active;
  logic [10:0]        r_shadow;
  logic               r_enable;
  logic               r_pending;
  logic               r_frame_done;
  logic               r_rvalid;
  logic [15:0]        r_rdata;
  logic [CNT_W-1:0]   r_run_cnt;
  logic [CNT_W-1:0]   r_edge_count;
  logic [15:0]        r_frame_cnt;

  logic               w_vs_rise;
  logic               w_vs_fall;
  logic               w_commit;
  logic               w_count_en;
  logic               w_wr_thr;
  logic               w_wr_ctrl;
  logic               w_force;
  logic               w_auto_rd;
  logic [10:0]        w_thr_wr;
  logic [15:0]        w_rd_mux;
  logic               w_unused;

  // Clamp a host-written threshold to the largest meaningful gradient sum.
  function automatic logic [10:0] clamp_max(input logic [10:0] v);
    clamp_max = (v > THR_MAX) ? THR_MAX : v;
  endfunction

`ifdef SOBEL_AUTO_THRESH_EN
  logic r_auto;

  // Saturating increment by STEP, ceiling THR_MAX.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    logic [11:0] s;
    s = {1'b0, v} + {1'b0, STEP};
    sat_inc = (s > {1'b0, THR_MAX}) ? THR_MAX : s[10:0];
  endfunction

  // Saturating decrement by STEP, floor THR_MIN.
  function automatic logic [10:0] sat_dec(input logic [10:0] v);
    if ({1'b0, v} < ({1'b0, THR_MIN} + {1'b0, STEP}))
      sat_dec = THR_MIN;
    else
      sat_dec = v - STEP;
  endfunction

  // Move the threshold toward the target edge density, with a dead band.
  function automatic logic [10:0] auto_adjust(input logic [10:0] thr,
                                              input logic [CNT_W-1:0] cnt);
    if (cnt > (TARGET_EDGES + HYST))
      auto_adjust = sat_inc(thr);
    else if (cnt < (TARGET_EDGES - HYST))
      auto_adjust = sat_dec(thr);
    else
      auto_adjust = thr;
  endfunction

  // Auto-adjust enable bit, only present when the feature is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_auto <= 1'b0;
    else if (w_wr_ctrl)
      r_auto <= cfg_wdata[2];
  end

  assign w_auto_rd = r_auto;
  assign w_unused  = ^cfg_wdata;
`else
  assign w_auto_rd = 1'b0;
  assign w_unused  = ^{cfg_wdata, THR_MIN, TARGET_EDGES, HYST, STEP};
`endif

  assign w_vs_rise = vsync & ~r_vsync_q;
  assign w_vs_fall = ~vsync & r_vsync_q;
  assign w_wr_thr  = cfg_wr_en && (cfg_addr == 2'd0);
  assign w_wr_ctrl = cfg_wr_en && (cfg_addr == 2'd1);
  assign w_force   = w_wr_ctrl && cfg_wdata[1];
  assign w_thr_wr  = clamp_max(cfg_wdata[10:0]);

  // Register vsync once for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vsync_q <= 1'b0;
    else
      r_vsync_q <= vsync;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_WAIT_BLANK;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and per-state strobes; partial frames after reset are skipped.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      S_WAIT_BLANK: begin
        if (w_vs_fall)
          w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        w_count_en = href & clken & edge_bit;
        if (w_vs_rise)
          w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_WAIT_BLANK;
    endcase
  end

  // Shadow threshold, written by the host at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_shadow <= THR_DEFAULT;
    else if (w_wr_thr)
      r_shadow <= w_thr_wr;
  end

  // Enable bit; force_commit is a strobe and is never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_enable <= 1'b1;
    else if (w_wr_ctrl)
      r_enable <= cfg_wdata[0];
  end

  // Active threshold: forced copy, frame-boundary commit, or auto adjust.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_active <= THR_DEFAULT;
    else if (w_force)
      r_active <= r_shadow;
    else if (w_commit) begin
      if (r_pending)
        r_active <= r_shadow;
`ifdef SOBEL_AUTO_THRESH_EN
      else if (r_auto)
        r_active <= auto_adjust(r_active, r_run_cnt);
`endif
    end
  end

  // Pending flag; a write landing on the commit cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pending <= 1'b0;
    else if (w_wr_thr)
      r_pending <= 1'b1;
    else if (w_force || w_commit)
      r_pending <= 1'b0;
  end

  // Per-frame edge counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_run_cnt <= '0;
    else if (w_commit)
      r_run_cnt <= '0;
    else if (w_count_en && (r_run_cnt != {CNT_W{1'b1}}))
      r_run_cnt <= r_run_cnt + CNT_ONE;
  end

  // Frame statistics and the frame-done pulse, updated at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_count <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      if (w_commit) begin
        r_edge_count <= r_run_cnt;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    w_rd_mux = '0;
    case (cfg_addr)
      2'd0:    w_rd_mux = {5'd0, r_active};
      2'd1:    w_rd_mux = {13'd0, w_auto_rd, 1'b0, r_enable};
      2'd2:    w_rd_mux = r_edge_count[15:0];
      default: w_rd_mux = r_frame_cnt;
    endcase
  end

  // Registered read data with a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= cfg_rd_en;
      if (cfg_rd_en)
        r_rdata <= w_rd_mux;
    end
  end

  assign sobel_threshold = r_enable ? r_active : THR_OFF;
  assign cfg_pending     = r_pending;
  assign frame_done      = r_frame_done;
  assign edge_count      = r_edge_count;
  assign frame_cnt       = r_frame_cnt;
  assign cfg_rdata       = r_rdata;
  assign cfg_rvalid      = r_rvalid;

endmodule
